// File: rtl/pipe_stage_elastic.sv
// Elastic inter-stage pipeline register: 2-entry skid buffer with valid/ready
// handshake, synchronous flush and a saturating downstream-stall counter.
//
// state     | meaning
// OCC_EMPTY | no entry held, out_valid=0
// OCC_ONE   | main register M holds the head entry
// OCC_TWO   | M holds the head, skid register S holds the next entry
module pipe_stage_elastic #(
   parameter int unsigned      WIDTH       = 32,
   parameter logic [WIDTH-1:0] RESET_VAL   = '0,
   parameter bit               ZERO_BUBBLE = 1'b1,
   parameter int unsigned      CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic [1:0]       occupancy,
   output logic [CNT_W-1:0] stall_cnt,
   input  logic             stall_clr
);

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_TWO   = 2'd2
   } occ_e;

   localparam logic [CNT_W-1:0] STALL_ONE = CNT_W'(1);

   occ_e             r_state;
   logic [WIDTH-1:0] r_m;
   logic [WIDTH-1:0] r_s;
   logic             r_in_ready;
   logic [CNT_W-1:0] r_stall_cnt;

   occ_e             w_state_nxt;
   logic [WIDTH-1:0] w_m_nxt;
   logic [WIDTH-1:0] w_s_nxt;
   logic             w_in_ready_nxt;
   logic             w_out_valid;
   logic             w_accept;
   logic             w_drain;
   logic             w_stall;
   logic             w_stall_max;

   assign w_out_valid = (r_state != OCC_EMPTY);
   assign w_accept    = in_valid & r_in_ready;
   assign w_drain     = w_out_valid & out_ready;
   assign w_stall     = w_out_valid & ~out_ready;
   assign w_stall_max = &r_stall_cnt;

   always_comb begin
      w_state_nxt = r_state;
      w_m_nxt     = r_m;
      w_s_nxt     = r_s;
      if (flush) begin
         w_state_nxt = OCC_EMPTY;
      end else begin
         case (r_state)
            OCC_EMPTY: begin
               if (w_accept) begin
                  w_state_nxt = OCC_ONE;
                  w_m_nxt     = in_data;
               end
            end
            OCC_ONE: begin
               if (w_accept && w_drain) begin
                  w_m_nxt = in_data;
               end else if (w_accept) begin
                  w_state_nxt = OCC_TWO;
                  w_s_nxt     = in_data;
               end else if (w_drain) begin
                  w_state_nxt = OCC_EMPTY;
               end
            end
            OCC_TWO: begin
               // in_ready is low here, so only a drain can move the state
               if (w_drain) begin
                  w_state_nxt = OCC_ONE;
                  w_m_nxt     = r_s;
               end
            end
            default: begin
               w_state_nxt = OCC_EMPTY;
            end
         endcase
      end
      w_in_ready_nxt = (w_state_nxt != OCC_TWO);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= OCC_EMPTY;
         r_m        <= RESET_VAL;
         r_s        <= RESET_VAL;
         r_in_ready <= 1'b1;
      end else begin
         r_state    <= w_state_nxt;
         r_m        <= w_m_nxt;
         r_s        <= w_s_nxt;
         r_in_ready <= w_in_ready_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
      end else if (stall_clr) begin
         r_stall_cnt <= '0;
      end else if (w_stall && !w_stall_max) begin
         r_stall_cnt <= r_stall_cnt + STALL_ONE;
      end
   end

   generate
      if (ZERO_BUBBLE) begin : g_zero_bubble
         assign out_data = w_out_valid ? r_m : RESET_VAL;
      end else begin : g_hold_bubble
         assign out_data = r_m;
      end
   endgenerate

   assign in_ready  = r_in_ready;
   assign out_valid = w_out_valid;
   assign occupancy = r_state;
   assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic: scoreboard queue of expected drains
// plus point checks of handshake, occupancy and stall counter.
module tb_pipe_stage_elastic;

   logic       clk;
   logic       rst_n;
   logic       flush;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_ready;
   logic [1:0] occupancy;
   logic [3:0] stall_cnt;
   logic       stall_clr;

   logic       b_flush;
   logic       b_in_valid;
   logic [7:0] b_in_data;
   logic       b_in_ready;
   logic       b_out_valid;
   logic [7:0] b_out_data;
   logic       b_out_ready;
   logic [1:0] b_occupancy;
   logic [3:0] b_stall_cnt;
   logic       b_stall_clr;

   int n_tests = 0;
   int n_fail  = 0;
   logic [7:0] exp_q[$];

   pipe_stage_elastic #(
      .WIDTH(8), .RESET_VAL(8'h00), .ZERO_BUBBLE(1'b1), .CNT_W(4)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .occupancy(occupancy), .stall_cnt(stall_cnt), .stall_clr(stall_clr)
   );

   pipe_stage_elastic #(
      .WIDTH(8), .RESET_VAL(8'hA5), .ZERO_BUBBLE(1'b0), .CNT_W(4)
   ) u_dut_hold (
      .clk(clk), .rst_n(rst_n), .flush(b_flush),
      .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
      .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(b_out_ready),
      .occupancy(b_occupancy), .stall_cnt(b_stall_cnt), .stall_clr(b_stall_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // scoreboard monitor: every drain must match the oldest expected payload
   always @(negedge clk) begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_unexpected: got %0h, expected no output", out_data);
         end else begin
            chk("drain_data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      out_ready = 1'b0; stall_clr = 1'b0;
      b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = 8'h00;
      b_out_ready = 1'b1; b_stall_clr = 1'b0;
      repeat (3) tick();

      chk("rst_occ", occupancy, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 8'h00);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_stall_cnt", stall_cnt, 0);
      chk("rst_hold_out_data", b_out_data, 8'hA5);
      rst_n = 1'b1;

      // stream 1..4 with free downstream
      out_ready = 1'b1;
      for (int d = 1; d <= 4; d++) begin
         in_valid = 1'b1;
         in_data  = 8'(d);
         exp_q.push_back(8'(d));
         tick();
         chk("stream_out_valid", out_valid, 1);
         chk("stream_in_ready", in_ready, 1);
         chk("stream_occ", occupancy, 1);
      end
      in_valid = 1'b0;
      tick();
      chk("stream_idle_occ", occupancy, 0);
      chk("stream_stall_cnt", stall_cnt, 0);

      // backpressure: A held, B skids, C held off
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'h0A;
      exp_q.push_back(8'h0A);
      exp_q.push_back(8'h0B);
      exp_q.push_back(8'h0C);
      tick();
      chk("bp_occ_one", occupancy, 1);
      in_data = 8'h0B;
      tick();
      chk("bp_occ_two", occupancy, 2);
      chk("bp_in_ready_low", in_ready, 0);
      in_data = 8'h0C;
      tick();
      tick();
      chk("bp_held_occ", occupancy, 2);
      chk("bp_held_out", out_data, 8'h0A);
      chk("bp_stall_cnt", stall_cnt, 3);
      out_ready = 1'b1;
      tick();
      chk("bp_rel_occ", occupancy, 1);
      chk("bp_rel_in_ready", in_ready, 1);
      tick();
      in_valid = 1'b0;
      tick();
      chk("bp_done_occ", occupancy, 0);
      chk("bp_done_stall", stall_cnt, 3);

      // flush while full, with a new offer in the same cycle
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'h05;
      tick();
      in_data = 8'h06;
      tick();
      chk("fl_pre_occ", occupancy, 2);
      in_data = 8'h07;
      flush   = 1'b1;
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("fl_occ", occupancy, 0);
      chk("fl_out_valid", out_valid, 0);
      chk("fl_out_data", out_data, 8'h00);
      chk("fl_in_ready", in_ready, 1);
      chk("fl_stall_kept", stall_cnt, 5);
      out_ready = 1'b1;
      tick();
      tick();
      chk("fl_after_valid", out_valid, 0);

      // stall counter saturation and clear priority
      stall_clr = 1'b1;
      tick();
      stall_clr = 1'b0;
      chk("sat_cleared", stall_cnt, 0);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'h11;
      exp_q.push_back(8'h11);
      tick();
      in_valid = 1'b0;
      repeat (20) tick();
      chk("sat_max", stall_cnt, 15);
      tick();
      chk("sat_hold", stall_cnt, 15);
      stall_clr = 1'b1;
      tick();
      chk("sat_clr", stall_cnt, 0);
      stall_clr = 1'b0;
      tick();
      chk("sat_restart", stall_cnt, 1);
      out_ready = 1'b1;
      tick();
      tick();

      // async reset between edges while full
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'h21;
      tick();
      in_data = 8'h22;
      tick();
      in_valid = 1'b0;
      chk("ar_pre_occ", occupancy, 2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_out_valid", out_valid, 0);
      chk("ar_in_ready", in_ready, 1);
      chk("ar_occ", occupancy, 0);
      chk("ar_out_data", out_data, 8'h00);
      chk("ar_stall_cnt", stall_cnt, 0);
      tick();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 8'h09;
      exp_q.push_back(8'h09);
      tick();
      in_valid = 1'b0;
      chk("ar_first_valid", out_valid, 1);
      chk("ar_first_data", out_data, 8'h09);
      tick();

      // ZERO_BUBBLE=0 instance keeps last payload when idle
      b_in_valid = 1'b1;
      b_in_data  = 8'h3C;
      tick();
      b_in_valid = 1'b0;
      chk("hold_valid", b_out_valid, 1);
      chk("hold_data", b_out_data, 8'h3C);
      tick();
      chk("hold_idle_valid", b_out_valid, 0);
      chk("hold_idle_data", b_out_data, 8'h3C);
      tick();
      chk("hold_idle_data2", b_out_data, 8'h3C);
      chk("zb_idle_data", out_data, 8'h00);

      chk("queue_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
